bcd_updown_scan: RTL and testbench

BCD_UPDOWN_SCAN -- requirements
Module: bcd_updown_scan

---
 rtl/bcd_scan_pkg.sv | 38 +++
 rtl/btn_debounce.sv | 68 ++++++
 rtl/bcd_updown_scan.sv | 139 +++++++++++++
 tb/tb_bcd_updown_scan.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_pkg.sv
// Shared definitions for the BCD up/down counter with multiplexed display.
//   deb_state_e : per-button debounce FSM states
//   SEG_TAB     : hex 7-segment codes, active-low, bit 6 = CA .. bit 0 = CG
//   SEG_BLANK   : all segments off
package bcd_scan_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESS   = 3'd1,
    WAIT1   = 3'd2,
    HELD    = 3'd3,
    RELEASE = 3'd4,
    WAIT0   = 3'd5
  } deb_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry 15 first so that SEG_TAB[d] is the code for digit d.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> Moore debounce FSM -> one-cycle press pulse.
//   clk, reset : clock, async active-high reset
//   btn_raw    : asynchronous button level, active-high
//   pulse      : high for exactly one cycle per physical press (state PRESS)
// WAIT1/WAIT0 each last exactly DEB_CYCLES cycles and ignore the input, so
// bounce on either edge cannot create extra pulses.
module btn_debounce
  import bcd_scan_pkg::*;
#(
  parameter int DEB_CYCLES = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int TW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  deb_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          btn_s;

  assign btn_s = sync_q[1];
  assign pulse = (state_q == PRESS);

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:    if (btn_s) state_d = PRESS;
      PRESS: begin
        timer_d = '0;
        state_d = WAIT1;
      end
      WAIT1: begin
        if (timer_q == T_LAST) state_d = HELD;
        else                   timer_d = timer_q + TW'(1);
      end
      HELD:    if (!btn_s) state_d = RELEASE;
      RELEASE: begin
        timer_d = '0;
        state_d = WAIT0;
      end
      WAIT0: begin
        if (timer_q == T_LAST) state_d = IDLE;
        else                   timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/bcd_updown_scan.sv
// NDIG-digit BCD up/down/clear counter driven by three debounced buttons,
// shown on a time-multiplexed common-anode 7-segment display.
//   clk, reset                 : clock, async active-high reset
//   btn_up/btn_down/btn_clr    : raw asynchronous buttons, active-high
//   blank_en                   : suppress leading zeros (digit 0 always shown)
//   seg                        : segment cathodes, bit 6 = CA, active-low
//   an                         : anodes, one-hot-low, an[0] = least significant
//   count_bcd                  : counter value, digit i in bits [4i+3:4i]
//   wrap                       : one-cycle pulse with the update that wrapped
module bcd_updown_scan
  import bcd_scan_pkg::*;
#(
  parameter int NDIG        = 8,
  parameter int DEB_CYCLES  = 100_000,
  parameter int SCAN_CYCLES = 100_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_clr,
  input  logic              blank_en,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic [4*NDIG-1:0] count_bcd,
  output logic              wrap
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NDIG - 1);

  logic up_p, dn_p, clr_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up  (.clk(clk), .reset(reset), .btn_raw(btn_up),   .pulse(up_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn  (.clk(clk), .reset(reset), .btn_raw(btn_down), .pulse(dn_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (.clk(clk), .reset(reset), .btn_raw(btn_clr),  .pulse(clr_p));

  // ---------------- counter ----------------
  logic [NDIG-1:0][3:0] count_q, count_d;
  logic                 wrap_q, wrap_d;
  logic                 cy;  // ripple carry (up) or borrow (down)

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    cy      = 1'b0;
    if (clr_p) begin
      count_d = '0;
    end else if (up_p && !dn_p) begin
      cy = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
        if (cy) begin
          if (count_q[i] >= 4'd9) count_d[i] = 4'd0;
          else begin
            count_d[i] = count_q[i] + 4'd1;
            cy         = 1'b0;
          end
        end
      end
      wrap_d = cy;
    end else if (dn_p && !up_p) begin
      cy = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
        if (cy) begin
          if (count_q[i] == 4'd0) count_d[i] = 4'd9;
          else begin
            count_d[i] = count_q[i] - 4'd1;
            cy         = 1'b0;
          end
        end
      end
      wrap_d = cy;
    end
  end

  // ---------------- scanner ----------------
  logic [SW-1:0] scan_q, scan_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == S_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // ---------------- encoder ----------------
  // lz[i]: digits i..NDIG-1 are all zero.
  logic [NDIG-1:0] lz;
  logic            allz;
  logic [6:0]      seg_q, seg_d;
  logic [NDIG-1:0] an_q, an_d;

  always_comb begin
    lz   = '0;
    allz = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      allz  = allz & (count_q[i] == 4'd0);
      lz[i] = allz;
    end
  end

  // seg and an are both derived from idx_q and registered together, so the
  // displayed digit always matches the active anode.
  always_comb begin
    seg_d = SEG_TAB[count_q[idx_q]];
    if (blank_en && (idx_q != '0) && lz[idx_q]) seg_d = SEG_BLANK;
    an_d        = '1;
    an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_TAB[0];
      an_q    <= ~(NDIG'(1));
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_bcd_updown_scan.sv
// Directed bench for bcd_updown_scan with NDIG=4, DEB_CYCLES=4, SCAN_CYCLES=2.
module tb_bcd_updown_scan;

  localparam int NDIG = 4;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0, reset = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_clr = 1'b0, blank_en = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] count_bcd;
  logic        wrap;

  int n_chk = 0, n_err = 0, wrap_cnt = 0;

  bcd_updown_scan #(.NDIG(NDIG), .DEB_CYCLES(4), .SCAN_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .btn_clr(btn_clr), .blank_en(blank_en), .seg(seg), .an(an),
    .count_bcd(count_bcd), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Counts cycles with wrap high; a one-cycle pulse adds exactly 1.
  always @(negedge clk) if (!reset && wrap) wrap_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold long enough to reach HELD, then stay low until the FSM is back in IDLE.
  task automatic press(input logic u, input logic d, input logic c);
    btn_up = u; btn_down = d; btn_clr = c;
    tick(8);
    btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    tick(10);
  endtask

  task automatic press_n(input int n, input logic u, input logic d);
    repeat (n) press(u, d, 1'b0);
  endtask

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_tab [4];
    int seen [4];
    int hist [12];
    int k;
    exp_tab[0] = e0; exp_tab[1] = e1; exp_tab[2] = e2; exp_tab[3] = e3;
    for (int d = 0; d < 4; d++) seen[d] = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      k = an_idx(an);
      hist[t] = k;
      if (k < 0) chk({tag, "_an_onehot"}, 32'(an), 32'hE);
      else begin
        chk($sformatf("%s_seg_d%0d", tag, k), 32'(seg), 32'(exp_tab[k]));
        seen[k]++;
      end
    end
    for (int d = 0; d < 4; d++) chk($sformatf("%s_seen_d%0d", tag, d), 32'(seen[d] > 0), 32'd1);
    for (int t = 0; t < 10; t += 3)
      chk($sformatf("%s_step%0d", tag, t), 32'(hist[t+2]), 32'((hist[t] + 1) % 4));
  endtask

  initial begin
    // reset state
    tick(3);
    @(negedge clk);
    chk("rst_count", 32'(count_bcd), 32'h0);
    chk("rst_wrap",  32'(wrap),      32'h0);
    chk("rst_an",    32'(an),        32'hE);
    chk("rst_seg",   32'(seg),       32'(S0));
    #2 reset = 1'b0;
    tick(3);

    // single held press: latency and no auto-repeat
    btn_up = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("up_edge3", 32'(count_bcd), 32'h0);
    @(negedge clk);
    chk("up_edge4", 32'(count_bcd), 32'h1);
    tick(16);
    btn_up = 1'b0;
    tick(12);
    chk("up_held_once", 32'(count_bcd), 32'h1);
    chk("up_nowrap", 32'(wrap_cnt), 32'd0);

    // down to zero, then wrap both ways
    press(1'b0, 1'b1, 1'b0);
    chk("dn_to_0", 32'(count_bcd), 32'h0);
    press(1'b0, 1'b1, 1'b0);
    chk("dn_wrap_val", 32'(count_bcd), 32'h9999);
    chk("dn_wrap_pulse", 32'(wrap_cnt), 32'd1);
    press(1'b1, 1'b0, 1'b0);
    chk("up_wrap_val", 32'(count_bcd), 32'h0);
    chk("up_wrap_pulse", 32'(wrap_cnt), 32'd2);

    // carry and borrow across a digit boundary
    press_n(9, 1'b1, 1'b0);
    chk("up_to_9", 32'(count_bcd), 32'h9);
    press(1'b1, 1'b0, 1'b0);
    chk("carry_10", 32'(count_bcd), 32'h10);
    press(1'b0, 1'b1, 1'b0);
    chk("borrow_9", 32'(count_bcd), 32'h9);
    press(1'b1, 1'b0, 1'b0);

    // bouncing press counts once
    btn_up = 1'b1; tick(1);
    btn_up = 1'b0; tick(1);
    btn_up = 1'b1; tick(1);
    btn_up = 1'b0; tick(20);
    chk("glitch_once", 32'(count_bcd), 32'h11);

    // up and down together cancel
    press(1'b1, 1'b1, 1'b0);
    chk("updn_cancel", 32'(count_bcd), 32'h11);

    // clear never wraps
    press(1'b0, 1'b0, 1'b1);
    chk("clr_val", 32'(count_bcd), 32'h0);
    chk("clr_nowrap", 32'(wrap_cnt), 32'd2);

    // display at 0042
    press_n(42, 1'b1, 1'b0);
    chk("cnt_42", 32'(count_bcd), 32'h42);
    blank_en = 1'b1;
    tick(2);
    scan_check("blank", S2, S4, SB, SB);
    tick(1);
    blank_en = 1'b0;
    tick(2);
    scan_check("noblank", S2, S4, S0, S0);
    tick(1);

    // reset during WAIT1 with the button held throughout
    press_n(6, 1'b0, 1'b1);
    chk("cnt_36", 32'(count_bcd), 32'h36);
    btn_up = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("cnt_37", 32'(count_bcd), 32'h37);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count_bcd), 32'h0);
    chk("mid_rst_an",    32'(an),        32'hE);
    chk("mid_rst_seg",   32'(seg),       32'(S0));
    chk("mid_rst_wrap",  32'(wrap),      32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(30);
    chk("post_rst_pulse", 32'(count_bcd), 32'h1);
    btn_up = 1'b0;
    tick(12);
    chk("post_rst_once", 32'(count_bcd), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
